// File: rtl/fetch_pkg.sv
// Shared widths, sequencer state encoding and branch target arithmetic for the fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W = 12;
  localparam int INS_W  = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Offset is relative to the word after the presented instruction; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] ins_pc,
                                                      input logic [7:0]        offset);
    return ins_pc + ADDR_W'(1) + {{(ADDR_W-8){offset[7]}}, offset};
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Next program-counter selection: jump over branch over sequential advance over hold.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic              run,
  input  logic              advance,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ins_pc,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_req,
  input  logic [7:0]        branch_offset,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic              redirect
);

  always_comb begin
    pc_nxt   = pc;
    redirect = 1'b0;
    if (run) begin
      if (jump_req) begin
        pc_nxt   = jump_target;
        redirect = 1'b1;
      end else if (branch_req) begin
        pc_nxt   = branch_target(ins_pc, branch_offset);
        redirect = 1'b1;
      end else if (advance) begin
        pc_nxt   = pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller feeding decode through a valid/ready instruction register.
// Build option FETCH_HALT_ON_ZERO_EN: an all-zero fetched word stops the sequencer in HALT.
//
// state   | meaning
// IDLE    | after reset, waiting for start; nothing captured
// RUN     | fetching one word per cycle when the output register is free
// HALT    | zero word seen; pc frozen, only rst leaves
module fetch_sequencer #(
  parameter int                ADDR_W   = 12,
  parameter int                INS_W    = 19,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  output logic [INS_W-1:0]  ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_req,
  input  logic [7:0]        branch_offset,
  output logic              halted
);
  import fetch_pkg::*;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              load, zero_word, advance, capture, redirect;

  assign imem_addr = pc;

  fetch_pc_next u_pc_next (
    .run           (state == ST_RUN),
    .advance       (advance),
    .pc            (pc),
    .ins_pc        (ins_pc),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .branch_req    (branch_req),
    .branch_offset (branch_offset),
    .pc_nxt        (pc_nxt),
    .redirect      (redirect)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    zero_word = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        load = !ins_valid || ins_ready;
`ifdef FETCH_HALT_ON_ZERO_EN
        zero_word = load && (imem_data == '0);
`endif
        advance = load && !zero_word;
        capture = advance && !redirect;
        // A redirect in the same cycle overrides the halt.
        if (zero_word && !redirect) state_nxt = ST_HALT;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ins_out   <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        ins_out   <= imem_data;
        ins_pc    <= pc;
        ins_valid <= 1'b1;
      end else if (state != ST_RUN || redirect || load) begin
        ins_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer; the memory model returns {7'h55, addr}, zero at address 11.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, ins_ready, jump_req, branch_req;
  logic [11:0] imem_addr, ins_pc, jump_target;
  logic [18:0] imem_data, ins_out;
  logic [7:0]  branch_offset;
  logic        ins_valid, halted;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  function automatic logic [18:0] mem_word(input logic [11:0] a);
    return (a == 12'd11) ? 19'd0 : {7'h55, a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ins_out       (ins_out),
    .ins_pc        (ins_pc),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .branch_req    (branch_req),
    .branch_offset (branch_offset),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ins(input string tag, input logic [11:0] pc_exp);
    chk({tag, "_valid"}, 32'(ins_valid), 32'd1);
    chk({tag, "_pc"}, 32'(ins_pc), 32'(pc_exp));
    chk({tag, "_word"}, 32'(ins_out), 32'(mem_word(pc_exp)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ins_ready = 1'b1;
    jump_req = 1'b0; jump_target = '0; branch_req = 1'b0; branch_offset = '0;
    step(); step();
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_ins", 32'(ins_out), 32'd0);
    chk("rst_pc", 32'(ins_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    rst = 1'b0;
    step();
    chk("idle_valid", 32'(ins_valid), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_valid", 32'(ins_valid), 32'd0);
    chk("start_addr", 32'(imem_addr), 32'd0);

    for (int k = 0; k <= 5; k++) begin
      step();
      chk_ins("seq", 12'(k));
    end

    ins_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ins("stall", 12'd5);
      chk("stall_addr", 32'(imem_addr), 32'd6);
    end
    ins_ready = 1'b1;
    step();
    chk_ins("resume", 12'd6);

    jump_req = 1'b1; jump_target = 12'd25;
    step();
    jump_req = 1'b0;
    chk("jmp25_bubble", 32'(ins_valid), 32'd0);
    step();
    chk_ins("jmp25", 12'd25);

    branch_req = 1'b1; branch_offset = 8'd3;
    step();
    branch_req = 1'b0;
    chk("br_fwd_bubble", 32'(ins_valid), 32'd0);
    chk("br_fwd_addr", 32'(imem_addr), 32'd29);
    step();
    chk_ins("br_fwd", 12'd29);
    step();
    chk_ins("seq30", 12'd30);

    branch_req = 1'b1; branch_offset = 8'hFE;
    step();
    branch_req = 1'b0;
    chk("br_back_addr", 32'(imem_addr), 32'd29);
    step();
    chk_ins("br_back", 12'd29);

    jump_req = 1'b1; jump_target = 12'd15; branch_req = 1'b1; branch_offset = 8'd3;
    step();
    jump_req = 1'b0; branch_req = 1'b0;
    chk("prio_addr", 32'(imem_addr), 32'd15);
    step();
    chk_ins("prio", 12'd15);

    jump_req = 1'b1; jump_target = 12'd4095;
    step();
    jump_req = 1'b0;
    step();
    chk_ins("top", 12'd4095);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    step();
    chk_ins("wrap", 12'd0);

    branch_req = 1'b1; branch_offset = 8'h80;
    step();
    branch_req = 1'b0;
    chk("br_wrap_addr", 32'(imem_addr), 32'd3969);
    step();
    chk_ins("br_wrap", 12'd3969);

    ins_ready = 1'b0;
    step();
    chk_ins("bp_hold", 12'd3969);
    jump_req = 1'b1; jump_target = 12'd9;
    step();
    jump_req = 1'b0;
    chk("bp_jmp_valid", 32'(ins_valid), 32'd0);
    chk("bp_jmp_addr", 32'(imem_addr), 32'd9);
    step();
    chk_ins("bp_fill", 12'd9);
    step();
    chk_ins("bp_hold9", 12'd9);
    chk("bp_hold9_addr", 32'(imem_addr), 32'd10);
    ins_ready = 1'b1;
    step();
    chk_ins("seq10", 12'd10);
    step();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("halt_valid", 32'(ins_valid), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", 32'(imem_addr), 32'd11);
    jump_req = 1'b1; jump_target = 12'd20;
    step();
    jump_req = 1'b0;
    chk("halt_jmp_addr", 32'(imem_addr), 32'd11);
    chk("halt_jmp_flag", 32'(halted), 32'd1);
    chk("halt_jmp_valid", 32'(ins_valid), 32'd0);
`else
    chk_ins("zero11", 12'd11);
    chk("zero11_halted", 32'(halted), 32'd0);
    step();
    chk_ins("seq12", 12'd12);
`endif

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(ins_valid), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    step(); step();
    chk("mid_rst_idle", 32'(ins_valid), 32'd0);
    chk("mid_rst_idle_addr", 32'(imem_addr), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_ins("restart", 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
